// File: rtl/axis_64to32.sv
// axis_64to32: splits 64-bit AXI-Stream beats into 32-bit words,
// low word first, with half-beat TKEEP and per-packet SRCDEST.
module axis_64to32 #(
  parameter int USER_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  AXIS_ACLK,
  input  logic                  AXIS_ARESETN,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  input  logic [63:0]           S_AXIS_TDATA,
  input  logic [1:0]            S_AXIS_TKEEP,
  input  logic                  S_AXIS_TLAST,
  input  logic [USER_WIDTH-1:0] S_AXIS_TUSER,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic [31:0]           M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  output logic [USER_WIDTH-1:0] M_AXIS_TUSER,
  output logic [USER_WIDTH-1:0] SRCDEST,
  output logic [CNT_WIDTH-1:0]  PKT_CNT
);

  typedef enum logic [1:0] {
    EMPTY,
    LO,
    HI
  } state_e;

  state_e                state_q, state_d;
  logic [63:0]           data_q;
  logic                  keep1_q;
  logic                  last_q;
  logic                  sop_q;
  logic [USER_WIDTH-1:0] tuser_q;
  logic [USER_WIDTH-1:0] srcdest_q;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic final_half;
  logic s_xfr;
  logic m_xfr;

  // Low keep bit carries no information: the low word is always present.
  logic unused_keep0;
  assign unused_keep0 = S_AXIS_TKEEP[0];

  assign final_half = (state_q == HI) |
                      ((state_q == LO) & ~keep1_q);

  assign M_AXIS_TVALID = (state_q != EMPTY);
  assign S_AXIS_TREADY = (state_q == EMPTY) |
                         (final_half & M_AXIS_TREADY);

  assign s_xfr = S_AXIS_TVALID & S_AXIS_TREADY;
  assign m_xfr = M_AXIS_TVALID & M_AXIS_TREADY;

  assign M_AXIS_TDATA = (state_q == HI) ? data_q[63:32]
                                        : data_q[31:0];
  assign M_AXIS_TUSER = tuser_q;
  assign SRCDEST      = srcdest_q;
  assign PKT_CNT      = cnt_q;

  // Output TLAST: a half-filled last beat ends on its low word.
  always_comb begin
    M_AXIS_TLAST = 1'b0;
    unique case (state_q)
      LO:      M_AXIS_TLAST = last_q & ~keep1_q;
      HI:      M_AXIS_TLAST = last_q;
      default: M_AXIS_TLAST = 1'b0;
    endcase
  end

  // Next state: walk LO -> HI per beat, refill when final half leaves.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (s_xfr) state_d = LO;
      end
      LO: begin
        if (m_xfr) begin
          if (keep1_q)    state_d = HI;
          else if (s_xfr) state_d = LO;
          else            state_d = EMPTY;
        end
      end
      HI: begin
        if (m_xfr) state_d = s_xfr ? LO : EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Packet counter advances on each delivered last word.
  always_comb begin
    cnt_d = cnt_q;
    if (m_xfr & M_AXIS_TLAST) cnt_d = cnt_q + 1'b1;
  end

  // State register.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) state_q <= EMPTY;
    else               state_q <= state_d;
  end

  // Beat buffer and sideband capture on each accepted input beat.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      data_q    <= '0;
      keep1_q   <= 1'b0;
      last_q    <= 1'b0;
      tuser_q   <= '0;
      srcdest_q <= '0;
      sop_q     <= 1'b1;
    end else if (s_xfr) begin
      data_q  <= S_AXIS_TDATA;
      keep1_q <= S_AXIS_TKEEP[1];
      last_q  <= S_AXIS_TLAST;
      tuser_q <= S_AXIS_TUSER;
      sop_q   <= S_AXIS_TLAST;
      if (sop_q) srcdest_q <= S_AXIS_TUSER;
    end
  end

  // Completed-packet counter register.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) cnt_q <= '0;
    else               cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_axis_64to32.sv
// tb_axis_64to32: scoreboard bench for the 64->32 down-converter
// with a word-queue reference model and randomized traffic.
module tb_axis_64to32;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [63:0]   s_data;
  logic [1:0]    s_keep;
  logic          s_last;
  logic [31:0]   s_user;
  logic          m_valid;
  logic          m_ready;
  logic [31:0]   m_data;
  logic          m_last;
  logic [31:0]   m_user;
  logic [31:0]   srcdest;
  logic [CW-1:0] pkt_cnt;

  axis_64to32 #(
    .USER_WIDTH(32),
    .CNT_WIDTH (CW)
  ) dut (
    .AXIS_ACLK    (clk),
    .AXIS_ARESETN (rst_n),
    .S_AXIS_TVALID(s_valid),
    .S_AXIS_TREADY(s_ready),
    .S_AXIS_TDATA (s_data),
    .S_AXIS_TKEEP (s_keep),
    .S_AXIS_TLAST (s_last),
    .S_AXIS_TUSER (s_user),
    .M_AXIS_TVALID(m_valid),
    .M_AXIS_TREADY(m_ready),
    .M_AXIS_TDATA (m_data),
    .M_AXIS_TLAST (m_last),
    .M_AXIS_TUSER (m_user),
    .SRCDEST      (srcdest),
    .PKT_CNT      (pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [31:0] u;
    logic        fin;
  } word_t;

  word_t         q[$];
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            acc_cyc = 0;
  int            mode = 0;
  int            pat = 0;
  logic          m_sop = 1'b1;
  logic [31:0]   exp_src = '0;
  logic [CW-1:0] exp_cnt = '0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Downstream ready generator.
  always @(posedge clk) begin
    #1;
    pat++;
    case (mode)
      0: m_ready = 1'b1;
      1: m_ready = ($urandom_range(0, 2) != 0);
      2: m_ready = ((pat % 4) == 0) ||
                   ((pat % 4) == 3);
      default: ;
    endcase
  end

  // Issue one beat; push its expected words when accepted.
  task automatic send(input logic [63:0] d,
                      input logic [1:0]  k,
                      input logic        l,
                      input logic [31:0] u);
    word_t w;
    bit    acc = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    s_user  = u;
    for (int i = 0; i < 1000 && !acc; i++) begin
      @(negedge clk);
      if (s_ready) begin
        acc = 1;
        acc_cyc = cyc;
        w.d = d[31:0];
        w.l = l & ~k[1];
        w.u = u;
        w.fin = ~k[1];
        q.push_back(w);
        if (k[1]) begin
          w.d = d[63:32];
          w.l = l;
          w.fin = 1'b1;
          q.push_back(w);
        end
        if (m_sop) exp_src = u;
        m_sop = l;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    s_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && q.size() != 0; i++)
      @(posedge clk);
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: pop and compare delivered words, check handshakes.
  logic        stall = 1'b0;
  logic [31:0] hd;
  logic        hl;
  logic [31:0] hu;
  always @(negedge clk) begin
    word_t w;
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, hd);
        chk("stall_last", m_last, hl);
        chk("stall_user", m_user, hu);
      end
      if (m_valid) begin
        if (q.size() == 0) begin
          chk("extra_word", 1, 0);
        end else begin
          w = q[0];
          chk("s_ready", s_ready, w.fin & m_ready);
          if (m_ready) begin
            w = q.pop_front();
            chk("m_data", m_data, w.d);
            chk("m_last", m_last, w.l);
            chk("m_user", m_user, w.u);
            if (w.l) exp_cnt = exp_cnt + 1'b1;
          end
        end
      end else begin
        chk("s_ready_empty", s_ready, 1);
      end
      stall = m_valid & ~m_ready;
      hd = m_data;
      hl = m_last;
      hu = m_user;
    end
  end

  // Sideband checks just after each active edge.
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      chk("srcdest", srcdest, exp_src);
      chk("pkt_cnt", pkt_cnt, exp_cnt);
    end
  end

  initial begin
    int n;
    int first;
    logic [1:0] k;
    rst_n   = 1'b0;
    m_ready = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_keep  = 2'b11;
    s_last  = 1'b0;
    s_user  = '0;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_data", m_data, 0);
    chk("rst_srcdest", srcdest, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single beat.
    send(64'h22222222_11111111, 2'b11, 1'b1, 32'hA5);
    drain();
    chk("single_srcdest", srcdest, 32'hA5);
    chk("single_cnt", pkt_cnt, 1);

    // Streaming: one beat every two cycles.
    send(64'h0000000B_0000000A, 2'b11, 1'b0, 32'h1);
    first = acc_cyc;
    send(64'h0000000D_0000000C, 2'b11, 1'b0, 32'h2);
    send(64'h0000000F_0000000E, 2'b11, 1'b0, 32'h3);
    send(64'h00000011_00000010, 2'b11, 1'b1, 32'h4);
    chk("stream_rate", acc_cyc - first, 6);
    drain();

    // Odd length.
    send(64'h44444444_55555555, 2'b11, 1'b0, 32'h6);
    send(64'hDEADBEEF_33333333, 2'b01, 1'b1, 32'h6);
    drain();

    // Backpressure 1,0,0,1.
    mode = 2;
    send(64'h12345678_9ABCDEF0, 2'b11, 1'b0, 32'h21);
    send(64'h0F0F0F0F_F0F0F0F0, 2'b11, 1'b0, 32'h22);
    send(64'hCAFEBABE_01234567, 2'b11, 1'b1, 32'h23);
    drain();

    // SRCDEST per packet.
    mode = 0;
    send(64'h1, 2'b11, 1'b0, 32'h7);
    send(64'h2, 2'b11, 1'b1, 32'h8);
    send(64'h3, 2'b11, 1'b1, 32'h9);
    drain();
    chk("srcdest_pkt2", srcdest, 32'h9);

    // Reset while stalled in the high half.
    mode = 3;
    m_ready = 1'b0;
    send(64'hBBBBBBBB_AAAAAAAA, 2'b11, 1'b1, 32'h55);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_cnt", pkt_cnt, 0);
    chk("mid_rst_ready", s_ready, 1);
    chk("mid_rst_src", srcdest, 0);
    q.delete();
    m_sop = 1'b1;
    exp_src = '0;
    exp_cnt = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mode = 0;
    @(posedge clk);
    #1;

    // Five packets wrap a 2-bit counter to 1.
    for (int i = 0; i < 5; i++)
      send({32'h0, 32'h100 + i}, 2'b11, 1'b1, i);
    drain();
    chk("cnt_wrap", pkt_cnt, 1);

    // Randomized traffic with random backpressure.
    mode = 1;
    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(1, 4);
      for (int b = 0; b < n; b++) begin
        k = 2'b11;
        if ($urandom_range(0, 7) == 0) k = 2'b01;
        if (b == n - 1 && $urandom_range(0, 1) == 1)
          k = 2'b01;
        send({$urandom, $urandom}, k, b == n - 1,
             $urandom);
        if ($urandom_range(0, 3) == 0)
          gap($urandom_range(1, 3));
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
